// File: rtl/priority_encoder_pkg.sv
// Shared widths and index type for the 8-to-3 priority encoder.
package priority_encoder_pkg;

    localparam int IN_W  = 8;
    localparam int OUT_W = 3;

    typedef logic [OUT_W-1:0] idx_t;

endpackage

// File: rtl/priority_encoder_8x3_if.sv
// Request/result bundle between a requester (master) and the encoder (slave).
interface priority_encoder_8x3_if
    import priority_encoder_pkg::*;
();

    logic [IN_W-1:0] I;
    idx_t            F;
    logic            valid;

    modport master (output I, input  F, input  valid);
    modport slave  (input  I, output F, output valid);

endinterface

// File: rtl/priority_encoder_8x3_core.sv
// Combinational top-down priority scan: index of the highest set request bit.
module priority_encoder_8x3_core
    import priority_encoder_pkg::*;
(
    input  logic [IN_W-1:0] I,
    output idx_t            F,
    output logic            valid
);

    // NOTE: every output gets a default before the scan so no path can infer a latch.
    always_comb begin
        F     = '0;
        valid = 1'b0;
        // Once a hit is recorded, lower bits are masked by !valid, so X/Z below
        // the leading one never reaches F or valid.
        for (int k = IN_W - 1; k >= 0; k--) begin
            if (!valid && I[k]) begin
                F     = idx_t'(k);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_encoder_8x3.sv
// Top: priority core plus an optional one-cycle output register selected by OUT_REG.
module priority_encoder_8x3
    import priority_encoder_pkg::*;
#(
    parameter bit OUT_REG = 1'b1
)(
    input  logic                   clk,
    input  logic                   rst_n,
    priority_encoder_8x3_if.slave  bus
);

    idx_t w_f;
    logic w_valid;

    priority_encoder_8x3_core u_core (
        .I     (bus.I),
        .F     (w_f),
        .valid (w_valid)
    );

    generate
        if (OUT_REG) begin : g_reg
            idx_t r_f;
            logic r_valid;

            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_f     <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_f     <= w_f;
                    r_valid <= w_valid;
                end
            end

            assign bus.F     = r_f;
            assign bus.valid = r_valid;
        end else begin : g_comb
            assign bus.F     = w_f;
            assign bus.valid = w_valid;
        end
    endgenerate

endmodule

// File: tb/tb_priority_encoder_8x3.sv
// Directed bench for priority_encoder_8x3: registered instance plus a combinational one.
module tb_priority_encoder_8x3;
    import priority_encoder_pkg::*;

    logic clk;
    logic rst_n;

    priority_encoder_8x3_if bus_r ();
    priority_encoder_8x3_if bus_c ();

    priority_encoder_8x3 #(.OUT_REG(1'b1)) u_dut_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_r.slave)
    );

    priority_encoder_8x3 #(.OUT_REG(1'b0)) u_dut_comb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_c.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Last registered result expected on the outputs, used to confirm latency.
    logic [2:0] prev_f;
    logic       prev_v;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, want %b", tag, obs, exp);
        end
    endtask

    // Drive I just after an edge, confirm old value still held, then check after the next edge.
    task automatic apply(input string tag, input logic [7:0] vec,
                         input logic [2:0] exp_f, input logic exp_v);
        bus_r.I = vec;
        #1;
        check({tag, "_hold_F"}, 8'(bus_r.F), 8'(prev_f));
        @(posedge clk);
        #1;
        check({tag, "_F"},     8'(bus_r.F),     8'(exp_f));
        check({tag, "_valid"}, 8'(bus_r.valid), 8'(exp_v));
        check({tag, "_noX"},   8'($isunknown({bus_r.F, bus_r.valid})), 8'd0);
        prev_f = exp_f;
        prev_v = exp_v;
    endtask

    typedef struct {
        logic [7:0] vec;
        logic [2:0] f;
        logic       v;
    } vec_t;

    vec_t walk [7];
    vec_t comb_vecs [5];

    initial begin
        walk[0] = '{8'b0000001x, 3'b001, 1'b1};
        walk[1] = '{8'b000001xx, 3'b010, 1'b1};
        walk[2] = '{8'b00001xxx, 3'b011, 1'b1};
        walk[3] = '{8'b0001xxxx, 3'b100, 1'b1};
        walk[4] = '{8'b001xxxxx, 3'b101, 1'b1};
        walk[5] = '{8'b01xxxxxx, 3'b110, 1'b1};
        walk[6] = '{8'b1xxxxxxx, 3'b111, 1'b1};

        comb_vecs[0] = '{8'b00000000, 3'b000, 1'b0};
        comb_vecs[1] = '{8'b00000001, 3'b000, 1'b1};
        comb_vecs[2] = '{8'b00001100, 3'b011, 1'b1};
        comb_vecs[3] = '{8'b01000000, 3'b110, 1'b1};
        comb_vecs[4] = '{8'b10000001, 3'b111, 1'b1};

        prev_f  = 3'b000;
        prev_v  = 1'b0;
        bus_c.I = 8'h00;

        // Reset asserted with all requests high: outputs zero without any clock edge.
        rst_n   = 1'b1;
        bus_r.I = 8'hFF;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_F",     8'(bus_r.F),     8'd0);
        check("rst_async_valid", 8'(bus_r.valid), 8'd0);
        @(posedge clk);
        #1;
        check("rst_hold_F",     8'(bus_r.F),     8'd0);
        check("rst_hold_valid", 8'(bus_r.valid), 8'd0);
        rst_n = 1'b1;

        apply("zero", 8'b00000000, 3'b000, 1'b0);
        apply("bit0", 8'b00000001, 3'b000, 1'b1);

        for (int i = 0; i < 7; i++)
            apply($sformatf("walk%0d", i + 1), walk[i].vec, walk[i].f, walk[i].v);

        apply("mix_5a", 8'b01011010, 3'b110, 1'b1);
        apply("mix_f3", 8'b11110011, 3'b111, 1'b1);
        apply("mix_24", 8'b00100100, 3'b101, 1'b1);

        apply("b2b_01", 8'b00000001, 3'b000, 1'b1);
        apply("b2b_80", 8'b10000000, 3'b111, 1'b1);
        apply("b2b_10", 8'b00010000, 3'b100, 1'b1);

        // Mid-stream reset pulse with a held request, then recovery on the first edge.
        apply("pre_rst", 8'b01000000, 3'b110, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_F",     8'(bus_r.F),     8'd0);
        check("midrst_valid", 8'(bus_r.valid), 8'd0);
        @(posedge clk);
        #1;
        check("midrst_hold_F", 8'(bus_r.F), 8'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_F",     8'(bus_r.F),     8'(3'b110));
        check("post_rst_valid", 8'(bus_r.valid), 8'd1);

        // Combinational instance: results appear with no clock edge.
        for (int i = 0; i < 5; i++) begin
            bus_c.I = comb_vecs[i].vec;
            #1;
            check($sformatf("comb%0d_F", i),     8'(bus_c.F),     8'(comb_vecs[i].f));
            check($sformatf("comb%0d_valid", i), 8'(bus_c.valid), 8'(comb_vecs[i].v));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/priority_encoder_8x3.md
PRIORITY_ENCODER_8X3 -- requirements
Module: priority_encoder_8x3

Interface
- REQ-001: Parameter OUT_REG, default 1, meaning: 1 = registered outputs with one-cycle latency; 0 = combinational outputs, with clk/rst_n unused.
- REQ-002: The block SHALL use one clock; reset SHALL be asynchronous and active-low.
- REQ-003: Port clk, input, 1 bit: rising-edge clock.
- REQ-004: Port rst_n, input, 1 bit: asynchronous active-low reset.
- REQ-005: Port I, input, 8 bits: request vector; bit 7 has the highest priority.
- REQ-006: Port F, output, 3 bits: binary index of the highest-priority asserted bit of I.
- REQ-007: Port valid, output, 1 bit: high when at least one bit of I is 1.

Function
- REQ-008: Encoding SHALL be F = index n of the highest set bit, scanned from bit 7 down to bit 0, for example:
  - 1xxxxxxx -> 111
  - 01xxxxxx -> 110
  - 0000001x -> 001
  - 00000001 -> 000
- REQ-009: Bits below the highest set bit SHALL be don't-care. An X or Z on any such lower bit SHALL NOT affect F or valid. Use a top-down priority structure, not a sum or one-hot decode.
- REQ-010: I = 00000000 SHALL produce F = 000 and valid = 0.
- REQ-011: With OUT_REG = 1, F and valid SHALL be registered. A change on I at one rising edge SHALL appear on the outputs after the next rising edge (latency 1 cycle). A new input SHALL be accepted every cycle with no handshake.
- REQ-012: With OUT_REG = 0, F and valid SHALL follow I combinationally with zero cycles of latency.
- REQ-013: If an X or Z occurs at or above the highest 1 bit, the output value is unspecified. The block SHALL still produce a 0/1 value on F in that case; it SHALL NOT hang.
- REQ-014: F SHALL always be exactly 3 bits, with no truncation or extension logic beyond the index.

Reset
- REQ-015: Asserting rst_n low SHALL immediately force F = 000 and valid = 0, independent of clk.
- REQ-016: While rst_n is low, the outputs SHALL hold their reset values regardless of I.
- REQ-017: After rst_n deasserts, the first rising edge SHALL capture the current I and present its encoding.
- REQ-018: Reset asserted mid-stream SHALL discard the registered result with no residual state.

Structure
- REQ-019: A shared package priority_encoder_pkg SHALL hold the constants IN_W = 8 and OUT_W = 3, plus a typedef for the 3-bit index.
- REQ-020: One combinational sub-module, priority_encoder_8x3_core (I -> F, valid), SHALL contain the priority logic.
- REQ-021: The top level SHALL contain only the OUT_REG-selected output register stage.

Verification (OUT_REG = 1, outputs checked one cycle after each input)
- REQ-022: Reset with rst_n = 0 and I = 11111111 -> F = 000 and valid = 0 immediately, without waiting for a clock edge.
- REQ-023: I = 00000000 -> F = 000, valid = 0. Then I = 00000001 -> F = 000, valid = 1.
- REQ-024: Walking leading one with X fill below it:
  - 0000001x -> 001
  - 000001xx -> 010
  - 00001xxx -> 011
  - 0001xxxx -> 100
  - 001xxxxx -> 101
  - 01xxxxxx -> 110
  - 1xxxxxxx -> 111
  - In every case valid = 1 and no X appears on the outputs.
- REQ-025: Mixed patterns: I = 01011010 -> F = 110; I = 11110011 -> F = 111; I = 00100100 -> F = 101.
- REQ-026: Back-to-back change every cycle (00000001, 10000000, 00010000) -> outputs 000, 111, 100 on consecutive cycles.
- REQ-027: Pulse rst_n low while I = 01000000 is held -> outputs go to 000/0 asynchronously. After release, the next edge gives F = 110, valid = 1.
